// File: rtl/controlador_multiplicador.sv
// Matrix multiplier C = A*B built around a single shared multiply-accumulate unit.
// It computes one product per cycle, with k innermost, i middle and j outermost.
module controlador_multiplicador #(
   parameter int Bit  = 3,
   parameter int EBit = 2*Bit+2,
   parameter int M    = 4,
   parameter int N    = 2,
   parameter int P    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  clr,
   input  logic [N*M*Bit-1:0]    in1,
   input  logic [M*P*Bit-1:0]    in2,
   output logic                  busy,
   output logic                  done,
   output logic [P*N*EBit-1:0]   out
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int JW = (P > 1) ? $clog2(P) : 1;
   localparam int KW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                state, state_next;
   logic [N*M*Bit-1:0]    a_reg;
   logic [M*P*Bit-1:0]    b_reg;
   logic [IW-1:0]         i;
   logic [JW-1:0]         j;
   logic [KW-1:0]         k;
   logic [EBit-1:0]       acc;
   logic [EBit-1:0]       acc_next;
   logic [Bit-1:0]        a_elem;
   logic [Bit-1:0]        b_elem;
   logic [2*Bit-1:0]      prod;
   logic [EBit-1:0]       prod_ext;
   logic                  k_last;
   logic                  i_last;
   logic                  j_last;

   assign k_last = (k == KW'(M-1));
   assign i_last = (i == IW'(N-1));
   assign j_last = (j == JW'(P-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (k_last && i_last && j_last) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == FIN);
   end

   // Product is zero-extended before accumulation; the sum wraps modulo 2^EBit.
   always_comb begin
      a_elem   = a_reg[int'(i)*M*Bit + int'(k)*Bit +: Bit];
      b_elem   = b_reg[int'(j)*M*Bit + int'(k)*Bit +: Bit];
      prod     = a_elem * b_elem;
      prod_ext = '0;
      prod_ext[2*Bit-1:0] = prod;
      acc_next = ((k == '0) ? '0 : acc) + prod_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         acc   <= '0;
         out   <= '0;
      end else if (!clr) begin
         if (state == IDLE && start) begin
            a_reg <= in1;
            b_reg <= in2;
            i     <= '0;
            j     <= '0;
            k     <= '0;
         end else if (state == RUN) begin
            acc <= acc_next;
            if (k_last) begin
               out[(int'(j)*N + int'(i))*EBit +: EBit] <= acc_next;
               k <= '0;
               if (i_last) begin
                  i <= '0;
                  j <= j_last ? '0 : j + 1'b1;
               end else begin
                  i <= i + 1'b1;
               end
            end else begin
               k <= k + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_controlador_multiplicador.sv
// Directed bench for controlador_multiplicador at default parameters (2x4 times 4x2, 8-bit results).
module tb_controlador_multiplicador;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        clr;
   logic [23:0] in1;
   logic [23:0] in2;
   logic        busy;
   logic        done;
   logic [31:0] out;

   int errors = 0;
   int checks = 0;

   controlador_multiplicador #(.Bit(3), .EBit(8), .M(4), .N(2), .P(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .clr   (clr),
      .in1   (in1),
      .in2   (in2),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [23:0] a;
      logic [23:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start on the current negedge, then verify the busy length, done timing and result.
   task automatic run_vec(input vec_t v);
      int busy_cnt;
      int done_cyc;
      busy_cnt = 0;
      done_cyc = 0;
      in1   = v.a;
      in2   = v.b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            done_cyc = c;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
      end
      check({v.name, " busy_cycles"}, busy_cnt, 16);
      check({v.name, " done_cycle"}, done_cyc, 17);
      check({v.name, " busy_in_fin"}, {31'd0, busy}, 32'd0);
      check({v.name, " out"}, out, v.exp);
      @(negedge clk);
      check({v.name, " done_one_cycle"}, {31'd0, done}, 32'd0);
      check({v.name, " out_hold"}, out, v.exp);
   endtask

   initial begin
      int done_cyc;
      int done_seen;

      vecs[0] = '{"ones",   24'o11111111, 24'o11111111, 32'h04040404};
      vecs[1] = '{"sevens", 24'o77777777, 24'o77777777, 32'hC4C4C4C4};
      vecs[2] = '{"mixed",  24'o07654321, 24'o00121001, 32'h10040505};
      vecs[3] = '{"rowzero", 24'o00002222, 24'o33333333, 32'h00180018};

      rst = 1'b1; start = 1'b0; clr = 1'b0; in1 = '0; in2 = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset out", out, 32'd0);
      rst = 1'b0;

      // The first start after reset release, then back-to-back runs through the table.
      foreach (vecs[n]) run_vec(vecs[n]);

      // Re-pulse start and disturb in1 during RUN; the result and timing must be unchanged.
      done_cyc = 0;
      in1 = vecs[2].a; in2 = vecs[2].b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) start = 1'b1;
         if (c == 6) begin start = 1'b0; in1 = 24'hABCDEF; in2 = 24'h123456; end
         if (done === 1'b1) begin done_cyc = c; break; end
         @(negedge clk);
      end
      check("disturb done_cycle", done_cyc, 17);
      check("disturb out", out, vecs[2].exp);
      @(negedge clk);
      check("disturb idle", {31'd0, busy | done}, 32'd0);

      // Abort with clr at cycle 8, then confirm that a fresh run is correct.
      done_seen = 0;
      in1 = vecs[1].a; in2 = vecs[1].b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (done === 1'b1) done_seen++;
         if (c == 8) clr = 1'b1;
         @(negedge clk);
      end
      clr = 1'b0;
      check("clr busy", {31'd0, busy}, 32'd0);
      check("clr done", {31'd0, done}, 32'd0);
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      check("clr no_done", done_seen, 0);
      run_vec(vecs[3]);

      // Assert rst between edges in mid-RUN; it must clear the block without waiting for a clock.
      done_seen = 0;
      in1 = vecs[0].a; in2 = vecs[0].b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst out", out, 32'd0);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      check("rst no_done", done_seen, 0);
      rst = 1'b0;
      run_vec(vecs[2]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/controlador_multiplicador.md
CONTROLADOR_MULTIPLICADOR -- requirements
Module: controlador_multiplicador

Interface
REQ-001 The block SHALL have parameter Bit, default 3, meaning the operand element width in bits.
REQ-002 The block SHALL have parameter EBit, default 2*Bit+2, meaning the result element width.
REQ-003 The block SHALL have parameter M, default 4, meaning the columns of A and the rows of B.
REQ-004 The block SHALL have parameter N, default 2, meaning the rows of A.
REQ-005 The block SHALL have parameter P, default 2, meaning the columns of B.
REQ-006 The block SHALL have a single clock and an asynchronous active-high reset: clk input 1 (rising-edge clock) and rst input 1 (asynchronous active-high reset).
REQ-007 The block SHALL have port start, input, 1 bit, meaning a request to capture the operands and begin the product.
REQ-008 The block SHALL have port clr, input, 1 bit, meaning a synchronous abort.
REQ-009 The block SHALL have port in1, input, N*M*Bit bits, meaning matrix A, with A[i][k] at in1[i*M*Bit+k*Bit +: Bit].
REQ-010 The block SHALL have port in2, input, M*P*Bit bits, meaning matrix B stored column-major, with B[k][j] at in2[j*M*Bit+k*Bit +: Bit].
REQ-011 The block SHALL have port busy, output, 1 bit, meaning a computation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.
REQ-013 The block SHALL have port out, output, P*N*EBit bits, meaning C = A*B, with C[i][j] at out[(j*N+i)*EBit +: EBit].

Function
REQ-014 The block SHALL compute C using one shared multiply-accumulate unit, performing one product A[i][k]*B[k][j] per cycle.
REQ-015 The block SHALL implement three states: IDLE, RUN and FIN.
REQ-016 In IDLE with start=1 and clr=0, the block SHALL, at the clock edge, register in1 and in2 into internal operand registers, zero i, j and k, and enter RUN.
REQ-017 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-018 In RUN, each cycle the block SHALL set acc <= (k==0 ? 0 : acc) + A[i][k]*B[k][j].
REQ-019 In RUN, the counter k SHALL be the innermost loop, i the middle loop and j the outer loop.
REQ-020 In RUN, on a cycle with k==M-1, the block SHALL write the new acc value into the result-register slot for C[i][j].
REQ-021 After processing the element with i=N-1, j=P-1 and k=M-1, the block SHALL go to FIN.
REQ-022 FIN SHALL last exactly one cycle and SHALL then return to IDLE.
REQ-023 busy SHALL be 1 exactly while in RUN, i.e. for N*P*M cycles following the start edge.
REQ-024 done SHALL be 1 exactly while in FIN.
REQ-025 The block SHALL treat all arithmetic as unsigned, with the 2*Bit-bit product zero-extended to EBit bits.
REQ-026 The block SHALL truncate the accumulator modulo 2^EBit; for the default parameters no overflow is possible (7*7*4=196).
REQ-027 The block SHALL ignore start while in RUN or FIN.
REQ-028 The block SHALL use only the captured operand registers during RUN, so changes on in1/in2 during RUN SHALL have no effect.
REQ-029 When clr=1, the block SHALL go to IDLE at the next edge from any state, with no done pulse.
REQ-030 On clr, out SHALL retain any elements already written, and its contents SHALL be undefined as a complete result.
REQ-031 clr SHALL have priority over start.
REQ-032 The block SHALL hold out stable from FIN until the next RUN writes its first element.
REQ-033 A start asserted in the cycle immediately after FIN, while in IDLE, SHALL be accepted, giving back-to-back operation.

Reset
REQ-034 While rst=1, asynchronously: the state SHALL be IDLE, busy=0, done=0, out=0, acc=0, i=j=k=0, and the operand registers SHALL be 0.
REQ-035 Reset asserted mid-RUN SHALL abort the computation immediately, with no done pulse.
REQ-036 After rst deasserts, the first start SHALL be acceptable on the first rising edge.

Verification (defaults: Bit=3, M=4, N=2, P=2, EBit=8, 16 MAC cycles)
REQ-037 The bench SHALL cover all elements =1: a start pulse -> busy high 16 cycles, then done high 1 cycle, and every C[i][j]=4 (out=32'h04040404).
REQ-038 The bench SHALL cover all elements =7: -> every C[i][j]=196 (8'hC4), with no overflow.
REQ-039 The bench SHALL cover A=[[1,2,3,4],[5,6,7,0]] and B columns [1,0,0,1],[2,1,0,0]: -> C[0][0]=5, C[1][0]=5, C[0][1]=4, C[1][1]=16.
REQ-040 The bench SHALL cover start re-pulsed at cycle 5 of RUN and in1 changed at cycle 6: -> identical result to the undisturbed run, and done at cycle 17.
REQ-041 The bench SHALL cover clr at cycle 8 of RUN: -> IDLE next cycle, busy=0, done never asserted; a new start then yields a correct result.
REQ-042 The bench SHALL cover rst asserted mid-RUN between clock edges: -> busy=0 and out=0 immediately; start after release yields a correct result.
